// File: rtl/board_scan_reader.sv
// Board readout: fetches one row at a time from board storage and streams it
// as single-bit pixels over valid/ready, counting live cells per frame scan.
module board_scan_reader #(
    parameter int unsigned ROWS  = 16,
    parameter int unsigned COLS  = 16,
    parameter int unsigned CNT_W = 9,
    localparam int unsigned RW   = $clog2(ROWS),
    localparam int unsigned CW   = $clog2(COLS)
) (
    input  logic             ClkPort,
    input  logic             reset_n,
    input  logic             start,
    output logic             rd_req,
    output logic [RW-1:0]    rd_row,
    input  logic             rd_valid,
    input  logic [COLS-1:0]  rd_data,
    output logic             px_valid,
    input  logic             px_ready,
    output logic             px_data,
    output logic [RW-1:0]    px_row,
    output logic [CW-1:0]    px_col,
    output logic             px_sof,
    output logic             px_eol,
    output logic             px_eof,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] frame_alive
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_STREAM,
        S_DONE
    } state_t;

    state_t           state, state_n;
    logic [RW-1:0]    row, row_n;
    logic [CW-1:0]    col, col_n;
    logic [COLS-1:0]  row_buf, row_buf_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] frame_alive_n;
    logic             xfer;

    logic             rd_req_n;
    logic [RW-1:0]    rd_row_n;
    logic             px_valid_n;
    logic             px_data_n;
    logic [RW-1:0]    px_row_n;
    logic [CW-1:0]    px_col_n;
    logic             px_sof_n;
    logic             px_eol_n;
    logic             px_eof_n;
    logic             busy_n;
    logic             done_n;

    // Next-state, datapath and registered-output next values
    always_comb begin
        state_n       = state;
        row_n         = row;
        col_n         = col;
        row_buf_n     = row_buf;
        cnt_n         = cnt;
        frame_alive_n = frame_alive;
        xfer          = px_valid && px_ready;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_REQ;
                    row_n   = '0;
                    col_n   = '0;
                    cnt_n   = '0;
                end
            end
            S_REQ: begin
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (rd_valid) begin
                    row_buf_n = rd_data;
                    col_n     = '0;
                    state_n   = S_STREAM;
                end
            end
            S_STREAM: begin
                if (xfer) begin
                    cnt_n = cnt + CNT_W'(row_buf[col]);
                    if (col == CW'(COLS - 1)) begin
                        col_n = '0;
                        if (row == RW'(ROWS - 1)) begin
                            state_n       = S_DONE;
                            frame_alive_n = cnt_n;
                        end else begin
                            row_n   = RW'(row + RW'(1));
                            state_n = S_REQ;
                        end
                    end else begin
                        col_n = CW'(col + CW'(1));
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        rd_req_n   = (state_n == S_REQ);
        rd_row_n   = row_n;
        px_valid_n = (state_n == S_STREAM);
        px_data_n  = px_valid_n ? row_buf_n[col_n] : 1'b0;
        px_row_n   = px_valid_n ? row_n : '0;
        px_col_n   = px_valid_n ? col_n : '0;
        px_sof_n   = px_valid_n && (row_n == '0) && (col_n == '0);
        px_eol_n   = px_valid_n && (col_n == CW'(COLS - 1));
        px_eof_n   = px_eol_n && (row_n == RW'(ROWS - 1));
        busy_n     = (state_n != S_IDLE);
        done_n     = (state_n == S_DONE);
    end

    // Control state and datapath registers
    always_ff @(posedge ClkPort or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            row     <= '0;
            col     <= '0;
            row_buf <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_n;
            row     <= row_n;
            col     <= col_n;
            row_buf <= row_buf_n;
            cnt     <= cnt_n;
        end
    end

    // Registered outputs
    always_ff @(posedge ClkPort or negedge reset_n) begin
        if (!reset_n) begin
            rd_req      <= 1'b0;
            rd_row      <= '0;
            px_valid    <= 1'b0;
            px_data     <= 1'b0;
            px_row      <= '0;
            px_col      <= '0;
            px_sof      <= 1'b0;
            px_eol      <= 1'b0;
            px_eof      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            frame_alive <= '0;
        end else begin
            rd_req      <= rd_req_n;
            rd_row      <= rd_row_n;
            px_valid    <= px_valid_n;
            px_data     <= px_data_n;
            px_row      <= px_row_n;
            px_col      <= px_col_n;
            px_sof      <= px_sof_n;
            px_eol      <= px_eol_n;
            px_eof      <= px_eof_n;
            busy        <= busy_n;
            done        <= done_n;
            frame_alive <= frame_alive_n;
        end
    end

endmodule

// File: tb/tb_board_scan_reader.sv
// Directed bench for board_scan_reader with a board-storage responder model.
module tb_board_scan_reader;

    logic        ClkPort;
    logic        reset_n;
    logic        start;
    logic        rd_req;
    logic [3:0]  rd_row;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        px_valid;
    logic        px_ready;
    logic        px_data;
    logic [3:0]  px_row;
    logic [3:0]  px_col;
    logic        px_sof;
    logic        px_eol;
    logic        px_eof;
    logic        busy;
    logic        done;
    logic [8:0]  frame_alive;

    board_scan_reader dut (
        .ClkPort     (ClkPort),
        .reset_n     (reset_n),
        .start       (start),
        .rd_req      (rd_req),
        .rd_row      (rd_row),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .px_valid    (px_valid),
        .px_ready    (px_ready),
        .px_data     (px_data),
        .px_row      (px_row),
        .px_col      (px_col),
        .px_sof      (px_sof),
        .px_eol      (px_eol),
        .px_eof      (px_eof),
        .busy        (busy),
        .done        (done),
        .frame_alive (frame_alive)
    );

    initial begin
        ClkPort = 1'b0;
        forever #5 ClkPort = ~ClkPort;
    end

    int n_assert = 0;
    int n_fail   = 0;

    // Board storage model
    logic [15:0] board [16];
    int          row3_extra = 0;
    bit          spur_en    = 0;
    bit          pending    = 0;
    logic [3:0]  prow       = '0;
    int          pcnt       = 0;

    // Frame observation results
    int idx, pix_err, stall_err, stall_cnt, rdrow_err, wait3;
    int done_cnt, done_cyc, ones_seen, fa_hold_err;
    logic [8:0] fa_done, fa_before;
    bit timeout;

    // Storage responder: answers each rd_req after 1 (+ row3_extra for row 3) cycles
    initial begin
        rd_valid = 1'b0;
        rd_data  = '0;
        forever begin
            @(negedge ClkPort);
            rd_valid = 1'b0;
            rd_data  = '0;
            if (!reset_n) begin
                pending = 0;
            end else if (pending) begin
                if (pcnt == 0) begin
                    rd_valid = 1'b1;
                    rd_data  = board[prow];
                    pending  = 0;
                end else begin
                    pcnt--;
                end
            end else if (spur_en && !rd_req && ($urandom_range(0, 2) == 0)) begin
                rd_valid = 1'b1;
                rd_data  = 16'hBEEF;
            end
            if (reset_n && rd_req) begin
                pending = 1;
                prow    = rd_row;
                pcnt    = (rd_row == 4'd3) ? row3_extra : 0;
            end
        end
    end

    // Start one frame and observe it until a few cycles after done
    task automatic run_frame(input bit toggle_ready, input bit spam_start);
        logic [12:0] snap;
        bit          stalled;
        int          cyc;
        int          r;
        int          c;
        idx = 0; pix_err = 0; stall_err = 0; stall_cnt = 0; rdrow_err = 0; wait3 = 0;
        done_cnt = 0; done_cyc = -1; ones_seen = 0; fa_hold_err = 0; fa_done = '0;
        fa_before = frame_alive; timeout = 0; stalled = 0; snap = '0;
        @(negedge ClkPort);
        start = 1'b1;
        px_ready = 1'b1;
        cyc = 0;
        while (1) begin
            @(negedge ClkPort);
            cyc++;
            start = spam_start && (done_cnt == 0) && ((cyc % 37) == 0);
            if (pending && rd_row !== prow) rdrow_err++;
            if (busy && !rd_req && !px_valid && !done && rd_row == 4'd3) wait3++;
            if (stalled && {px_valid, px_data, px_row, px_col, px_sof, px_eol, px_eof} !== snap)
                stall_err++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    fa_done  = frame_alive;
                end
            end else if (done_cnt == 0 && frame_alive !== fa_before) begin
                fa_hold_err++;
            end
            px_ready = toggle_ready ? ((cyc % 2) == 1) : 1'b1;
            stalled = 0;
            if (px_valid) begin
                if (px_ready) begin
                    if (idx < 256) begin
                        r = idx / 16;
                        c = idx % 16;
                        if (px_row !== 4'(r) || px_col !== 4'(c) || px_data !== board[r][c] ||
                            px_sof !== (idx == 0) || px_eol !== (c == 15) || px_eof !== (idx == 255))
                            pix_err++;
                    end else begin
                        pix_err++;
                    end
                    if (px_data) ones_seen++;
                    idx++;
                end else begin
                    stalled = 1;
                    stall_cnt++;
                    snap = {px_valid, px_data, px_row, px_col, px_sof, px_eol, px_eof};
                end
            end
            if ((done_cyc >= 0 && cyc >= done_cyc + 3) || cyc >= 4000) break;
        end
        if (done_cyc < 0) timeout = 1;
        start = 1'b0;
        px_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; px_ready = 1'b0;
        for (int r = 0; r < 16; r++) board[r] = '0;
        repeat (3) @(negedge ClkPort);
        n_assert++;
        if ({rd_req, rd_row, px_valid, px_data, px_row, px_col, px_sof, px_eol, px_eof,
             busy, done, frame_alive} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b px_valid=%b frame_alive=%0d, required all 0",
                     busy, px_valid, frame_alive);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge ClkPort);
        n_assert++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_all_zero();
        for (int r = 0; r < 16; r++) board[r] = 16'h0000;
        run_frame(0, 0);
        n_assert++; if (timeout) begin n_fail++; $display("FAIL zero_timeout: no done seen"); end
        n_assert++; if (idx !== 256) begin n_fail++; $display("FAIL zero_pixels: got %0d required 256", idx); end
        n_assert++; if (pix_err !== 0) begin n_fail++; $display("FAIL zero_pixel_fields: %0d bad pixels, required 0", pix_err); end
        n_assert++; if (done_cyc !== 289) begin n_fail++; $display("FAIL zero_done_cycle: got %0d required 289", done_cyc); end
        n_assert++; if (done_cnt !== 1) begin n_fail++; $display("FAIL zero_done_pulse: got %0d cycles required 1", done_cnt); end
        n_assert++; if (fa_done !== 9'd0) begin n_fail++; $display("FAIL zero_alive: got %0d required 0", fa_done); end
        n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_idle_after: busy=%b required 0", busy); end
    endtask

    task automatic test_diagonal();
        for (int r = 0; r < 16; r++) board[r] = 16'h0001 << r;
        run_frame(0, 0);
        n_assert++; if (pix_err !== 0 || idx !== 256) begin n_fail++; $display("FAIL diag_pixels: bad=%0d count=%0d required 0/256", pix_err, idx); end
        n_assert++; if (ones_seen !== 16) begin n_fail++; $display("FAIL diag_ones: got %0d required 16", ones_seen); end
        n_assert++; if (fa_done !== 9'd16) begin n_fail++; $display("FAIL diag_alive: got %0d required 16", fa_done); end
        n_assert++; if (done_cyc !== 289) begin n_fail++; $display("FAIL diag_done_cycle: got %0d required 289", done_cyc); end
    endtask

    task automatic test_stall();
        for (int r = 0; r < 16; r++) board[r] = 16'hFFFF;
        run_frame(1, 0);
        n_assert++; if (timeout || idx !== 256) begin n_fail++; $display("FAIL stall_pixels: got %0d required 256", idx); end
        n_assert++; if (pix_err !== 0) begin n_fail++; $display("FAIL stall_order: %0d bad pixels, required 0", pix_err); end
        n_assert++; if (stall_cnt == 0) begin n_fail++; $display("FAIL stall_seen: got %0d stalls required >0", stall_cnt); end
        n_assert++; if (stall_err !== 0) begin n_fail++; $display("FAIL stall_stable: %0d changes during stall, required 0", stall_err); end
        n_assert++; if (fa_done !== 9'd256) begin n_fail++; $display("FAIL stall_alive: got %0d required 256", fa_done); end
    endtask

    task automatic test_rd_delay();
        int exp_alive;
        int bad_idle;
        exp_alive = 0;
        for (int r = 0; r < 16; r++) begin
            board[r] = 16'(r * 16'h0913) ^ 16'hA5C3;
            exp_alive += $countones(board[r]);
        end
        spur_en = 1;
        bad_idle = 0;
        repeat (12) begin
            @(negedge ClkPort);
            if (busy || px_valid) bad_idle++;
        end
        n_assert++; if (bad_idle !== 0) begin n_fail++; $display("FAIL idle_spurious: %0d active cycles required 0", bad_idle); end
        row3_extra = 5;
        run_frame(0, 0);
        row3_extra = 0;
        spur_en = 0;
        n_assert++; if (rdrow_err !== 0) begin n_fail++; $display("FAIL delay_rd_row_hold: %0d changes required 0", rdrow_err); end
        n_assert++; if (wait3 !== 6) begin n_fail++; $display("FAIL delay_wait_row3: got %0d wait cycles required 6", wait3); end
        n_assert++; if (pix_err !== 0 || idx !== 256) begin n_fail++; $display("FAIL delay_pixels: bad=%0d count=%0d required 0/256", pix_err, idx); end
        n_assert++; if (fa_done !== 9'(exp_alive)) begin n_fail++; $display("FAIL delay_alive: got %0d required %0d", fa_done, exp_alive); end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 16; r++) board[r] = 16'h00FF;
        run_frame(0, 1);
        n_assert++; if (done_cnt !== 1) begin n_fail++; $display("FAIL b2b_done_count: got %0d required 1", done_cnt); end
        n_assert++; if (done_cyc !== 289) begin n_fail++; $display("FAIL b2b_done_cycle: got %0d required 289", done_cyc); end
        n_assert++; if (fa_hold_err !== 0) begin n_fail++; $display("FAIL b2b_alive_hold1: %0d early changes required 0", fa_hold_err); end
        n_assert++; if (fa_done !== 9'd128) begin n_fail++; $display("FAIL b2b_alive1: got %0d required 128", fa_done); end
        board[0] = 16'h0000;
        for (int r = 1; r < 16; r++) board[r] = 16'hFFFF;
        run_frame(0, 0);
        n_assert++; if (fa_hold_err !== 0) begin n_fail++; $display("FAIL b2b_alive_hold2: %0d early changes required 0", fa_hold_err); end
        n_assert++; if (fa_done !== 9'd240) begin n_fail++; $display("FAIL b2b_alive2: got %0d required 240", fa_done); end
    endtask

    task automatic test_reset_mid();
        bit streaming;
        for (int r = 0; r < 16; r++) board[r] = 16'h0F0F;
        @(negedge ClkPort);
        start = 1'b1;
        px_ready = 1'b1;
        @(negedge ClkPort);
        start = 1'b0;
        for (int i = 0; i < 100 && !px_row[2]; i++) @(negedge ClkPort);
        repeat (5) @(negedge ClkPort);
        streaming = px_valid;
        n_assert++; if (!streaming) begin n_fail++; $display("FAIL midreset_streaming: px_valid=%b required 1", px_valid); end
        #2 reset_n = 1'b0;
        #1;
        n_assert++;
        if ({rd_req, rd_row, px_valid, px_data, px_row, px_col, px_sof, px_eol, px_eof,
             busy, done, frame_alive} !== 29'd0) begin
            n_fail++;
            $display("FAIL midreset_async: busy=%b px_valid=%b px_row=%0d frame_alive=%0d required all 0",
                     busy, px_valid, px_row, frame_alive);
        end
        @(negedge ClkPort);
        px_ready = 1'b0;
        reset_n = 1'b1;
        @(negedge ClkPort);
        run_frame(0, 0);
        n_assert++; if (pix_err !== 0 || idx !== 256) begin n_fail++; $display("FAIL midreset_restart: bad=%0d count=%0d required 0/256", pix_err, idx); end
        n_assert++; if (done_cyc !== 289) begin n_fail++; $display("FAIL midreset_done_cycle: got %0d required 289", done_cyc); end
        n_assert++; if (fa_done !== 9'd128) begin n_fail++; $display("FAIL midreset_alive: got %0d required 128", fa_done); end
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_diagonal();
        test_stall();
        test_rd_delay();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/board_scan_reader.md
Name: board_scan_reader

Overview:
Reads the 16x16 Game of Life board back out of board storage, one row per request, and streams it as single-bit pixels over a valid/ready interface. It is the readout side of the board, the counterpart of the set-up path that writes rows in from the switches. Its consumers are the display and pixel-output logic. It also counts live cells per frame scan for the status display.

Parameters:
ROWS, 16, board rows; row index width RW = clog2(ROWS) = 4
COLS, 16, board columns (row word width); column index width CW = clog2(COLS) = 4
CNT_W, 9, live-cell counter width; must hold ROWS*COLS = 256

Ports:
ClkPort  in  1  system clock (100 MHz)
reset_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a frame scan when idle
rd_req  out  1  one-cycle row read strobe to board storage
rd_row  out  RW  row index for rd_req, held stable until rd_valid
rd_valid  in  1  storage returns row data; arbitrary latency >= 1 cycle after rd_req
rd_data  in  COLS  row contents; bit c = cell (row, c)
px_valid  out  1  pixel available
px_ready  in  1  consumer accepts pixel
px_data  out  1  cell value (1 = alive)
px_row  out  RW  pixel row
px_col  out  CW  pixel column
px_sof  out  1  first pixel of frame (row 0, col 0)
px_eol  out  1  last pixel of row (col COLS-1)
px_eof  out  1  last pixel of frame
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse when the frame completes
frame_alive  out  CNT_W  live-cell count of the last completed frame

Behaviour:
- Reset (async, reset_n=0): state=IDLE. All outputs 0: rd_req, rd_row, px_*, busy, done, frame_alive. Row buffer and counters cleared.
- States: IDLE, REQ, WAIT, STREAM, DONE.
- IDLE:
  - start=1 -> REQ next cycle; row=0, col=0, running count=0.
  - start in any other state is ignored.
- REQ:
  - rd_req=1 for exactly one cycle with rd_row=row.
  - Next state is WAIT.
- WAIT:
  - rd_row is held.
  - On rd_valid=1, rd_data is captured into the row buffer and the next state is STREAM with col=0.
  - rd_valid is ignored outside WAIT.
  - There is no timeout; WAIT holds indefinitely.
- STREAM:
  - px_valid=1; px_data=buffer[col]; px_row=row; px_col=col.
  - px_sof=(row==0 && col==0); px_eol=(col==COLS-1); px_eof=px_eol && (row==ROWS-1).
  - A transfer is a cycle with px_valid && px_ready. On each transfer, col increments and the running count increments if px_data=1.
  - px_ready=0 stalls the stream. All px_* outputs hold stable while px_valid is high and no transfer occurs.
  - Transfer at col=COLS-1:
    - row<ROWS-1 -> row+1, go to REQ (px_valid=0 during REQ/WAIT).
    - row=ROWS-1 -> go to DONE.
- DONE:
  - done=1 for one cycle; frame_alive <= final running count.
  - Next state is IDLE.
- frame_alive holds its value until the next DONE and is not cleared by start.
- Minimum latency:
  - start at cycle 0: rd_req at cycle 1; with rd_valid at cycle 2, first px_valid at cycle 3.
  - Per row (rd latency 1, px_ready tied 1): 2 + COLS cycles.
  - Full frame: start to done = 1 + ROWS*(COLS+2) = 289 cycles.
- Arithmetic:
  - col and row are compared to COLS-1 and ROWS-1 explicitly, so non-power-of-2 sizes never index past the board.
  - The running count cannot overflow at CNT_W=9 (max 256).
- Reset mid-frame returns to IDLE immediately. A partial count is never published to frame_alive.

Test Plan:
- Reset with reset_n=0 at arbitrary mid-STREAM cycle -> all outputs 0 asynchronously (before next edge); state IDLE; start afterwards restarts at row 0.
- Board all zero, rd latency 1, px_ready=1, start pulse -> 256 pixels all 0; sof only on (0,0); eol on every col 15; eof only on (15,15); done at cycle 289; frame_alive=0.
- Row r data = 16'h0001<<r (diagonal) -> px_data=1 exactly when px_row==px_col; frame_alive=16.
- All ones, px_ready toggling 1,0,1,0 -> every pixel delivered once in order with no duplicates or drops; outputs stable during stalls; frame_alive=256.
- rd_valid delayed 5 cycles on row 3, plus spurious rd_valid pulses in STREAM and IDLE -> rd_row=3 held throughout WAIT; spurious pulses ignored; the captured row matches the value present at the real rd_valid.
- start pulsed repeatedly during a scan -> ignored; exactly one done pulse; a second start after done launches a new frame; frame_alive keeps the previous value until the new done.
